// File: rtl/inst_mem_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_pkg
// Shared definitions for the instruction memory and the fetch stage that
// consumes its output.
//   INSTR_W   : instruction width in bits
//   NOP_WORD  : word returned for unmapped reads and loaded on reset
//   instr_t   : one instruction word
//   in_range(): word-index range check over the full 32-bit index
// -----------------------------------------------------------------------------
package inst_mem_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_WORD = 32'h0000_0000;

  // All 32 index bits take part in the compare so upper bits never alias
  // onto a valid word.
  function automatic logic in_range(input logic [31:0] idx,
                                    input int unsigned depth);
    return (idx < 32'(depth));
  endfunction

endpackage : inst_mem_pkg

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
// Write-accept logic for the program-load port of instruction_memory.
// Decides whether a load request targets a mapped word, presents the
// resulting array write, and counts accepted writes (saturating).
//
// Ports:
//   clk, rst_n   : clock (rising edge) and async active-low reset
//   prog_we      : load request, sampled on clk rising edge
//   prog_addr    : requested word index (full 32 bits checked)
//   prog_wdata   : instruction word to store
//   wr_en        : array write strobe for this cycle (in-range request)
//   wr_idx       : decoded word index for the array write
//   wr_data      : word to write
//   load_count   : accepted writes since reset, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [31:0]   prog_addr,
  input  instr_t        prog_wdata,
  output logic          wr_en,
  output logic [AW-1:0] wr_idx,
  output instr_t        wr_data,
  output logic [15:0]   load_count
);

  logic [15:0] load_count_q;
  logic [15:0] load_count_d;

  // Out-of-range requests are dropped entirely: no array write, no count.
  assign wr_en   = prog_we && in_range(prog_addr, DEPTH);
  assign wr_idx  = prog_addr[AW-1:0];
  assign wr_data = prog_wdata;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    load_count_d = load_count_q;
    if (wr_en && (load_count_q != 16'hFFFF)) begin
      load_count_d = load_count_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count_q <= 16'd0;
    end else begin
      load_count_q <= load_count_d;
    end
  end

  assign load_count = load_count_q;

endmodule : inst_mem_loader

// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
// Word-organised instruction memory for the fetch stage. The address is the
// word index; reads are combinational, program loads are clocked.
//
// Build option: define INST_MEM_PRELOAD_EN to add parameter INIT_FILE and the
// preload image INIT_IMAGE, load the array from INIT_IMAGE at time zero, and
// keep the array contents across reset (reset then clears only load_count).
//
// Ports:
//   clk, rst_n : clock (rising edge) and async active-low reset
//   address    : word index to fetch
//   read_data  : instruction at address, NOP_WORD when unmapped
//   addr_err   : address >= DEPTH
//   prog_we    : program-load write enable
//   prog_addr  : word index to write
//   prog_wdata : instruction to write
//   load_count : accepted program writes since reset, saturating
// -----------------------------------------------------------------------------
module instruction_memory
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter instr_t      NOP_WORD = inst_mem_pkg::NOP_WORD
`ifdef INST_MEM_PRELOAD_EN
  ,
  parameter string       INIT_FILE = "program.hex",
  parameter instr_t      INIT_IMAGE [DEPTH] = '{default: NOP_WORD}
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  output instr_t      read_data,
  output logic        addr_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  instr_t      prog_wdata,
  output logic [15:0] load_count
);

  instr_t          mem_q [DEPTH];

  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  instr_t          wr_data;

  inst_mem_loader #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .load_count (load_count)
  );

`ifdef INST_MEM_PRELOAD_EN
  // Preloaded program must survive reset, so the array has no reset branch.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] = INIT_IMAGE[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end
`else
  // NOTE: the array is deliberately reset word by word because software must
  // see NOP_WORD at every address after reset; this turns the storage into
  // flops rather than a RAM macro, acceptable at these depths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= NOP_WORD;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end
`endif

  // Combinational read: no bypass, so a same-word write shows up only after
  // the clock edge that commits it.
  always_comb begin
    addr_err  = !in_range(address, DEPTH);
    read_data = NOP_WORD;
    if (!addr_err) begin
      read_data = mem_q[address[AW-1:0]];
    end
  end

endmodule : instruction_memory

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] read_data;
  logic        addr_err;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic [15:0] load_count;

  instruction_memory #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .read_data  (read_data),
    .addr_err   (addr_err),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain word array plus an accepted-write counter.
  logic [31:0] ref_mem [DEPTH];
  int unsigned ref_count;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return (a < DEPTH) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
    ref_count = 0;
  endtask

  // One program-load cycle; the model commits at the same edge as the DUT.
  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    @(posedge clk);
    if (a < DEPTH) begin
      ref_mem[a] = d;
      if (ref_count < 32'hFFFF) ref_count++;
    end
    #1;
    prog_we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a);
    address = a;
    #1;
    check({tag, "_data"}, read_data, ref_read(a));
    check({tag, "_err"}, {31'b0, addr_err}, {31'b0, (a >= DEPTH)});
  endtask

  initial begin
    logic [31:0] a, d, w5_old;

    rst_n      = 1'b0;
    address    = 32'h0;
    prog_we    = 1'b0;
    prog_addr  = 32'h0;
    prog_wdata = 32'h0;
    ref_clear();

    // Reset state
    #12;
    check("rst_count", {16'h0, load_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Address sweep after reset, one step every 3 time units
    for (int i = 0; i <= 'h11; i++) begin
      address = i;
      #3;
      check("sweep_data", read_data, 32'h0);
      check("sweep_err", {31'b0, addr_err}, 32'h0);
    end

    // Basic program load and zero-latency read-back
    write_word(32'd1, 32'h2008_0005);
    write_word(32'd2, 32'h0109_5020);
    read_check("rd1", 32'd1);
    read_check("rd2", 32'd2);
    check("count2", {16'h0, load_count}, 32'd2);

    // Out-of-range reads and writes; 0x40 would alias onto word 0 if the
    // upper index bits were dropped
    read_check("oor40", 32'h40);
    read_check("oorFF", 32'hFFFF_FFFF);
    read_check("last", DEPTH - 1);
    write_word(32'h40, 32'hDEAD_BEEF);
    write_word(32'hFFFF_FFC1, 32'hCAFE_F00D);
    read_check("alias0", 32'd0);
    read_check("alias1", 32'd1);
    check("count_oor", {16'h0, load_count}, 32'd2);

    // Read during write to the same word: old before the edge, new after
    write_word(32'd5, 32'h1111_2222);
    w5_old  = ref_mem[5];
    address = 32'd5;
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = 32'd5;
    prog_wdata = 32'hAC0A_0004;
    #4;
    check("rdw_before", read_data, w5_old);
    @(posedge clk);
    ref_mem[5] = 32'hAC0A_0004;
    ref_count++;
    #1;
    prog_we = 1'b0;
    check("rdw_after", read_data, 32'hAC0A_0004);

    // Randomised loads, mostly in range with some far out of range
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 71));
      d = $urandom;
      write_word(a, d);
      if ((i % 5) == 0) read_check("rnd_rd", 32'($urandom_range(0, 79)));
    end
    for (int i = 0; i < int'(DEPTH); i += 7) read_check("rnd_sweep", i);
    check("rnd_count", {16'h0, load_count}, ref_count);

    // Asynchronous reset between edges clears everything immediately
    address = 32'd5;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    ref_clear();
    #1;
    check("arst_data", read_data, 32'h0);
    check("arst_count", {16'h0, load_count}, 32'h0);
    read_check("arst_oor", 32'h80);

    // A write presented while reset is held is dropped
    prog_we    = 1'b1;
    prog_addr  = 32'd3;
    prog_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    read_check("rst_wr_drop", 32'd3);
    check("rst_wr_count", {16'h0, load_count}, 32'h0);

    // First edge after release accepts a write
    @(negedge clk);
    rst_n = 1'b1;
    write_word(32'd3, 32'h8C08_0000);
    read_check("post_rst", 32'd3);
    check("post_count", {16'h0, load_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_instruction_memory
